// File: rtl/execute1.sv
// execute1 -- third pipeline stage (execute).
//
// Takes the registered decode bundle, computes the ALU / RV64M result and
// resolves conditional branches. It produces a registered bundle for the
// memory stage. Every op completes in one cycle except divide/remainder,
// which run an iterative radix-2 restoring divider and hold the decode
// stage with ex_stall until the result is registered.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid               decode bundle valid this cycle
//   in_pc                  PC of the instruction
//   in_alu_control         6-bit op code
//   in_alu_src             1: operand B = in_imm, 0: operand B = in_read_data2
//   in_read_data1          operand A
//   in_read_data2          register operand B / store data
//   in_imm                 sign-extended immediate
//   in_dest_register       rd
//   in_branch, in_br_funct3  conditional branch and its condition
//   in_reg_write, in_mem_read, in_mem_write, in_mem_or_reg  control passthrough
//   ex_stall               upstream must hold its bundle
//   out_*                  registered result bundle, out_valid marks it valid
module execute1 #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int DIV_CYCLES     = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [BUS_DATA_WIDTH-1:0] in_pc,
  input  logic [5:0]                in_alu_control,
  input  logic                      in_alu_src,
  input  logic [BUS_DATA_WIDTH-1:0] in_read_data1,
  input  logic [BUS_DATA_WIDTH-1:0] in_read_data2,
  input  logic [BUS_DATA_WIDTH-1:0] in_imm,
  input  logic [4:0]                in_dest_register,
  input  logic                      in_branch,
  input  logic [2:0]                in_br_funct3,
  input  logic                      in_reg_write,
  input  logic                      in_mem_read,
  input  logic                      in_mem_write,
  input  logic                      in_mem_or_reg,
  output logic                      ex_stall,
  output logic                      out_valid,
  output logic [BUS_DATA_WIDTH-1:0] out_alu_result,
  output logic [BUS_DATA_WIDTH-1:0] out_store_data,
  output logic [4:0]                out_dest_register,
  output logic                      out_reg_write,
  output logic                      out_mem_read,
  output logic                      out_mem_write,
  output logic                      out_mem_or_reg,
  output logic                      out_pc_src,
  output logic [BUS_DATA_WIDTH-1:0] out_branch_target
);

  localparam int W     = BUS_DATA_WIDTH;
  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_DONE} state_t;

  // Everything except the ALU result travels through the stage untouched.
  typedef struct packed {
    logic [W-1:0] store_data;
    logic [4:0]   dest;
    logic         reg_write;
    logic         mem_read;
    logic         mem_write;
    logic         mem_or_reg;
    logic         pc_src;
    logic [W-1:0] branch_target;
  } pass_t;

  function automatic logic [W-1:0] sext32(input logic [31:0] x);
    return {{(W-32){x[31]}}, x};
  endfunction

  logic [W-1:0] a, b;
  assign a = in_read_data1;
  assign b = in_alu_src ? in_imm : in_read_data2;

  // ---------------- divide decode and operand preparation ----------------
  logic is_div, div_word, div_signed, div_rem;
  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    is_div = 1'b0; div_word = 1'b0; div_signed = 1'b0; div_rem = 1'b0;
    case (in_alu_control)
      6'b100011: begin is_div = 1'b1; div_signed = 1'b1; end
      6'b100100: begin is_div = 1'b1; end
      6'b100101: begin is_div = 1'b1; div_signed = 1'b1; div_rem = 1'b1; end
      6'b100110: begin is_div = 1'b1; div_rem = 1'b1; end
      6'b101000: begin is_div = 1'b1; div_word = 1'b1; div_signed = 1'b1; end
      6'b101001: begin is_div = 1'b1; div_word = 1'b1; end
      6'b101010: begin is_div = 1'b1; div_word = 1'b1; div_signed = 1'b1; div_rem = 1'b1; end
      6'b101011: begin is_div = 1'b1; div_word = 1'b1; div_rem = 1'b1; end
      default: ;
    endcase
  end

  // W divides are widened to 64 bits (sign- or zero-extended) so one 64-bit
  // divider serves both widths; the low 32 bits of the 64-bit result equal
  // the 32-bit result, including the zero-divisor and overflow cases.
  logic [W-1:0] div_a, div_b, div_a_mag, div_b_mag;
  logic         div_a_neg, div_b_neg;
  always_comb begin
    div_a = a;
    div_b = b;
    if (div_word) begin
      div_a = div_signed ? sext32(a[31:0]) : {{(W-32){1'b0}}, a[31:0]};
      div_b = div_signed ? sext32(b[31:0]) : {{(W-32){1'b0}}, b[31:0]};
    end
  end
  assign div_a_neg = div_signed & div_a[W-1];
  assign div_b_neg = div_signed & div_b[W-1];
  assign div_a_mag = div_a_neg ? -div_a : div_a;
  assign div_b_mag = div_b_neg ? -div_b : div_b;

  // ---------------- single-cycle ALU ----------------
  // One 128-bit multiplier; operand extension selects mulh/mulhsu/mulhu.
  logic         mul_a_signed, mul_b_signed;
  logic [2*W-1:0] mul_a, mul_b, prod;
  assign mul_a_signed = (in_alu_control == 6'b100000) || (in_alu_control == 6'b100001);
  assign mul_b_signed = (in_alu_control == 6'b100000);
  assign mul_a = {{W{mul_a_signed & a[W-1]}}, a};
  assign mul_b = {{W{mul_b_signed & b[W-1]}}, b};
  assign prod  = mul_a * mul_b;

  logic [W-1:0] alu_result;
  always_comb begin
    alu_result = '0;
    case (in_alu_control)
      6'b000001, 6'b001100: alu_result = a + b;
      6'b001101:            alu_result = a - b;
      6'b000010, 6'b001111: alu_result = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
      6'b000011, 6'b010000: alu_result = {{(W-1){1'b0}}, a < b};
      6'b000100, 6'b010001: alu_result = a ^ b;
      6'b000101, 6'b010100: alu_result = a | b;
      6'b000110, 6'b010101: alu_result = a & b;
      6'b000111, 6'b001110: alu_result = a << b[5:0];
      6'b001000, 6'b010010: alu_result = a >> b[5:0];
      6'b001001, 6'b010011: alu_result = $signed(a) >>> b[5:0];
      6'b010110, 6'b011010: alu_result = sext32(a[31:0] + b[31:0]);
      6'b011011:            alu_result = sext32(a[31:0] - b[31:0]);
      6'b010111, 6'b011100: alu_result = sext32(a[31:0] << b[4:0]);
      6'b011000, 6'b011101: alu_result = sext32(a[31:0] >> b[4:0]);
      6'b011001, 6'b011110: alu_result = sext32($signed(a[31:0]) >>> b[4:0]);
      6'b011111:            alu_result = prod[W-1:0];
      6'b100000, 6'b100001, 6'b100010: alu_result = prod[2*W-1:W];
      6'b100111:            alu_result = sext32(prod[31:0]);
      default:              alu_result = '0;
    endcase
  end

  // Branch condition compares against the register operand, never imm.
  logic br_cond;
  always_comb begin
    br_cond = 1'b0;
    case (in_br_funct3)
      3'b000: br_cond = (a == in_read_data2);
      3'b001: br_cond = (a != in_read_data2);
      3'b100: br_cond = ($signed(a) <  $signed(in_read_data2));
      3'b101: br_cond = ($signed(a) >= $signed(in_read_data2));
      3'b110: br_cond = (a <  in_read_data2);
      3'b111: br_cond = (a >= in_read_data2);
      default: br_cond = 1'b0;
    endcase
  end

  pass_t pass_in;
  assign pass_in = '{store_data:    in_read_data2,
                     dest:          in_dest_register,
                     reg_write:     in_reg_write,
                     mem_read:      in_mem_read,
                     mem_write:     in_mem_write,
                     mem_or_reg:    in_mem_or_reg,
                     pc_src:        in_branch & br_cond,
                     branch_target: in_pc + in_imm};

  // ---------------- control FSM ----------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             stall;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && is_div) begin
          state_d = DIV_RUN;
          stall   = 1'b1;
        end
      end
      DIV_RUN: begin
        stall = 1'b1;
        if (cnt_q == CNT_LAST) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        stall   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall is combinational from the inputs; force it low while in reset.
  assign ex_stall = stall & rst_n;

  // ---------------- divider datapath ----------------
  logic [W-1:0] quo_q, rem_q, divisor_q;
  logic         a_neg_q, b_neg_q, div_zero_q, word_q, rem_op_q;
  pass_t        cap_q;

  // Restoring step: shift in the next dividend bit, subtract when it fits.
  // A zero divisor always fits, leaving quotient all ones and rem = dividend.
  logic [W:0]   shifted, diff;
  logic         fits;
  assign shifted = {rem_q, quo_q[W-1]};
  assign diff    = shifted - {1'b0, divisor_q};
  assign fits    = ~diff[W];

  // Quotient sign fix is skipped for a zero divisor so it stays all ones.
  logic [W-1:0] quo_fix, rem_fix, div_raw, div_result;
  assign quo_fix    = ((a_neg_q ^ b_neg_q) && !div_zero_q) ? -quo_q : quo_q;
  assign rem_fix    = a_neg_q ? -rem_q : rem_q;
  assign div_raw    = rem_op_q ? rem_fix : quo_fix;
  assign div_result = word_q ? sext32(div_raw[31:0]) : div_raw;

  // ---------------- output / datapath registers ----------------
  pass_t        out_q;
  logic [W-1:0] result_q;
  logic         valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      divisor_q  <= '0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
      word_q     <= 1'b0;
      rem_op_q   <= 1'b0;
      cap_q      <= '0;
      out_q      <= '0;
      result_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid && is_div) begin
            cnt_q      <= '0;
            quo_q      <= div_a_mag;
            rem_q      <= '0;
            divisor_q  <= div_b_mag;
            a_neg_q    <= div_a_neg;
            b_neg_q    <= div_b_neg;
            div_zero_q <= (div_b_mag == '0);
            word_q     <= div_word;
            rem_op_q   <= div_rem;
            cap_q      <= pass_in;
          end else if (in_valid) begin
            out_q    <= pass_in;
            result_q <= alu_result;
            valid_q  <= 1'b1;
          end
        end
        DIV_RUN: begin
          cnt_q <= cnt_q + 1'b1;
          rem_q <= fits ? diff[W-1:0] : shifted[W-1:0];
          quo_q <= {quo_q[W-2:0], fits};
        end
        DIV_DONE: begin
          out_q    <= cap_q;
          result_q <= div_result;
          valid_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_valid         = valid_q;
  assign out_alu_result    = result_q;
  assign out_store_data    = out_q.store_data;
  assign out_dest_register = out_q.dest;
  assign out_reg_write     = out_q.reg_write;
  assign out_mem_read      = out_q.mem_read;
  assign out_mem_write     = out_q.mem_write;
  assign out_mem_or_reg    = out_q.mem_or_reg;
  assign out_pc_src        = out_q.pc_src;
  assign out_branch_target = out_q.branch_target;

endmodule

// File: tb/tb_execute1.sv
// tb_execute1 -- scoreboard bench for execute1.
//
// The stimulus side drives directed and random decode bundles and pushes
// the expected result bundle, including the cycle it must appear in, into
// a queue. A separate monitor pops and compares whenever out_valid is seen.
module tb_execute1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] in_pc;
  logic [5:0]  in_alu_control;
  logic        in_alu_src;
  logic [63:0] in_read_data1, in_read_data2, in_imm;
  logic [4:0]  in_dest_register;
  logic        in_branch;
  logic [2:0]  in_br_funct3;
  logic        in_reg_write, in_mem_read, in_mem_write, in_mem_or_reg;
  logic        ex_stall, out_valid;
  logic [63:0] out_alu_result, out_store_data, out_branch_target;
  logic [4:0]  out_dest_register;
  logic        out_reg_write, out_mem_read, out_mem_write, out_mem_or_reg, out_pc_src;

  execute1 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pc(in_pc),
    .in_alu_control(in_alu_control), .in_alu_src(in_alu_src),
    .in_read_data1(in_read_data1), .in_read_data2(in_read_data2), .in_imm(in_imm),
    .in_dest_register(in_dest_register), .in_branch(in_branch), .in_br_funct3(in_br_funct3),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_mem_or_reg(in_mem_or_reg), .ex_stall(ex_stall), .out_valid(out_valid),
    .out_alu_result(out_alu_result), .out_store_data(out_store_data),
    .out_dest_register(out_dest_register), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_mem_or_reg(out_mem_or_reg), .out_pc_src(out_pc_src),
    .out_branch_target(out_branch_target)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [5:0]  op;
    logic        alu_src;
    logic [63:0] pc, a, rd2, imm;
    logic [4:0]  dest;
    logic        branch;
    logic [2:0]  f3;
    logic        rw, mr, mw, mor;
  } txn_t;

  typedef struct {
    logic [63:0] result, store, target;
    logic        pc_src;
    logic [8:0]  ctl;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] sx(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  function automatic logic is_div_op(input logic [5:0] op);
    return op inside {6'b100011, 6'b100100, 6'b100101, 6'b100110,
                      6'b101000, 6'b101001, 6'b101010, 6'b101011};
  endfunction

  function automatic logic [63:0] model_result(input txn_t t);
    logic [63:0]  a, b, hu;
    logic [31:0]  a32u, b32u, p32;
    int           a32, b32;
    longint       sa, sbv;
    logic [127:0] pu;
    logic         w_ovf, d_ovf;
    a = t.a;
    b = t.alu_src ? t.imm : t.rd2;
    sa = a; sbv = b;
    a32u = a[31:0]; b32u = b[31:0];
    a32 = a32u; b32 = b32u;
    pu  = {64'd0, a} * {64'd0, b};
    hu  = pu[127:64];
    p32 = a32u * b32u;
    d_ovf = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    w_ovf = (a32u == 32'h8000_0000) && (b32u == 32'hFFFF_FFFF);
    case (t.op)
      6'b000001, 6'b001100: return a + b;
      6'b001101:            return a - b;
      6'b000010, 6'b001111: return (sa < sbv) ? 64'd1 : 64'd0;
      6'b000011, 6'b010000: return (a < b) ? 64'd1 : 64'd0;
      6'b000100, 6'b010001: return a ^ b;
      6'b000101, 6'b010100: return a | b;
      6'b000110, 6'b010101: return a & b;
      6'b000111, 6'b001110: return a << b[5:0];
      6'b001000, 6'b010010: return a >> b[5:0];
      6'b001001, 6'b010011: return 64'(sa >>> b[5:0]);
      6'b010110, 6'b011010: return sx(a32u + b32u);
      6'b011011:            return sx(a32u - b32u);
      6'b010111, 6'b011100: return sx(a32u << b[4:0]);
      6'b011000, 6'b011101: return sx(a32u >> b[4:0]);
      6'b011001, 6'b011110: return sx(32'(a32 >>> b[4:0]));
      6'b011111:            return pu[63:0];
      // High halves of signed products from the unsigned product:
      // a negative operand x contributes -(other << 64).
      6'b100000: return hu - (a[63] ? b : 64'd0) - (b[63] ? a : 64'd0);
      6'b100001: return hu - (a[63] ? b : 64'd0);
      6'b100010: return hu;
      6'b100111: return sx(p32);
      6'b100011: begin
        if (b == 64'd0) return '1;
        if (d_ovf)      return a;
        return 64'(sa / sbv);
      end
      6'b100100: return (b == 64'd0) ? '1 : a / b;
      6'b100101: begin
        if (b == 64'd0) return a;
        if (d_ovf)      return 64'd0;
        return 64'(sa % sbv);
      end
      6'b100110: return (b == 64'd0) ? a : a % b;
      6'b101000: begin
        if (b32u == 32'd0) return '1;
        if (w_ovf)         return sx(a32u);
        return sx(32'(a32 / b32));
      end
      6'b101001: return (b32u == 32'd0) ? '1 : sx(a32u / b32u);
      6'b101010: begin
        if (b32u == 32'd0) return sx(a32u);
        if (w_ovf)         return 64'd0;
        return sx(32'(a32 % b32));
      end
      6'b101011: return (b32u == 32'd0) ? sx(a32u) : sx(a32u % b32u);
      default:   return 64'd0;
    endcase
  endfunction

  function automatic logic model_taken(input txn_t t);
    longint sa, sr;
    logic   c;
    sa = t.a; sr = t.rd2;
    case (t.f3)
      3'b000:  c = (t.a == t.rd2);
      3'b001:  c = (t.a != t.rd2);
      3'b100:  c = (sa < sr);
      3'b101:  c = (sa >= sr);
      3'b110:  c = (t.a < t.rd2);
      3'b111:  c = (t.a >= t.rd2);
      default: c = 1'b0;
    endcase
    return t.branch && c;
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'hFFFF_FFFF_8000_0000;
      5: return 64'h0000_0000_7FFF_FFFF;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  function automatic logic [5:0] rand_op();
    int r;
    logic [5:0] op;
    r = $urandom_range(0, 19);
    if (r < 3) begin
      do op = 6'($urandom_range(35, 43)); while (op == 6'd39);
    end else if (r == 3) begin
      do op = 6'($urandom_range(0, 63)); while (op inside {[6'd1:6'd43]});
    end else begin
      op = ($urandom_range(0, 15) == 0) ? 6'd39 : 6'($urandom_range(1, 34));
    end
    return op;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.op      = rand_op();
    t.alu_src = 1'($urandom_range(0, 1));
    t.pc      = {$urandom(), $urandom()};
    t.a       = rand_operand();
    t.rd2     = rand_operand();
    t.imm     = rand_operand();
    t.dest    = 5'($urandom());
    t.branch  = ($urandom_range(0, 3) == 0);
    t.f3      = 3'($urandom());
    t.rw      = 1'($urandom()); t.mr = 1'($urandom());
    t.mw      = 1'($urandom()); t.mor = 1'($urandom());
    return t;
  endfunction

  function automatic txn_t mk(input logic [5:0] op, input logic [63:0] a, rd2, imm,
                              input logic src);
    txn_t t;
    t = rand_txn();
    t.op = op; t.a = a; t.rd2 = rd2; t.imm = imm; t.alu_src = src; t.branch = 1'b0;
    return t;
  endfunction

  task automatic apply(input txn_t t, input logic v);
    in_valid         = v;
    in_pc            = t.pc;
    in_alu_control   = t.op;
    in_alu_src       = t.alu_src;
    in_read_data1    = t.a;
    in_read_data2    = t.rd2;
    in_imm           = t.imm;
    in_dest_register = t.dest;
    in_branch        = t.branch;
    in_br_funct3     = t.f3;
    in_reg_write     = t.rw;
    in_mem_read      = t.mr;
    in_mem_write     = t.mw;
    in_mem_or_reg    = t.mor;
  endtask

  task automatic push_exp(input txn_t t, input int ecyc);
    exp_t e;
    e.result = model_result(t);
    e.store  = t.rd2;
    e.target = t.pc + t.imm;
    e.pc_src = model_taken(t);
    e.ctl    = {t.dest, t.rw, t.mr, t.mw, t.mor};
    e.cyc    = ecyc;
    sb.push_back(e);
  endtask

  // Called just after a rising edge with the DUT idle. A non-divide result
  // appears one edge later; a divide result DIV_CYCLES+2 edges later with
  // ex_stall high for all cycles in between. During a divide the next
  // bundle (if any) is already presented with in_valid held high.
  task automatic send(input txn_t t, input bit have_next, input txn_t nxt);
    bit d;
    int sc;
    d = is_div_op(t.op);
    apply(t, 1'b1);
    push_exp(t, cyc + (d ? 66 : 1));
    @(negedge clk);
    check("stall_on_issue", 64'(ex_stall), 64'(d));
    @(posedge clk); #1;
    if (d) begin
      sc = 0;
      if (have_next) apply(nxt, 1'b1);
      else           apply(rand_txn(), 1'b0);
      repeat (65) begin
        @(negedge clk);
        if (ex_stall) sc++;
        @(posedge clk);
      end
      #1;
      check("stall_cycles", 64'(sc), 64'd65);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      apply(rand_txn(), 1'b0);
      @(posedge clk); #1;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_result"}, out_alu_result, 64'd0);
    check({tag, "_store"},  out_store_data, 64'd0);
    check({tag, "_target"}, out_branch_target, 64'd0);
    check({tag, "_ctl"}, 64'({ex_stall, out_valid, out_dest_register, out_reg_write,
                              out_mem_read, out_mem_write, out_mem_or_reg, out_pc_src}), 64'd0);
  endtask

  // ---------------- monitor ----------------
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'(out_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result",     out_alu_result,    mon_e.result);
        check("pc_src",     64'(out_pc_src),   64'(mon_e.pc_src));
        check("target",     out_branch_target, mon_e.target);
        check("store_data", out_store_data,    mon_e.store);
        check("ctl", 64'({out_dest_register, out_reg_write, out_mem_read,
                          out_mem_write, out_mem_or_reg}), 64'(mon_e.ctl));
        check("latency",    64'(cyc),          64'(mon_e.cyc));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  txn_t t1, t2, cur, nxt, none;
  int   w;

  initial begin
    none = rand_txn();

    // Reset held for three cycles with live random inputs.
    rst_n = 1'b0;
    apply(rand_txn(), 1'b1);
    repeat (3) begin
      @(negedge clk);
      check_zero("reset");
      apply(rand_txn(), 1'b1);
    end
    apply(rand_txn(), 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle(3);
    check("idle_valid", 64'(out_valid), 64'd0);

    // add then sub back to back.
    send(mk(6'b001100, 64'd5, 64'd0, -64'sd3, 1'b1), 0, none);
    check("dir_add", out_alu_result, 64'd2);
    send(mk(6'b001101, 64'd0, 64'd1, 64'd0, 1'b0), 0, none);
    check("dir_sub", out_alu_result, 64'hFFFF_FFFF_FFFF_FFFF);

    // W ops: addw overflow and sraiw.
    send(mk(6'b011010, 64'h7FFF_FFFF, 64'd1, 64'd0, 1'b0), 0, none);
    check("dir_addw", out_alu_result, 64'hFFFF_FFFF_8000_0000);
    send(mk(6'b011001, 64'h8000_0000, 64'd0, 64'd4, 1'b1), 0, none);
    check("dir_sraiw", out_alu_result, 64'hFFFF_FFFF_F800_0000);

    // bltu taken, blt with the same operands not taken.
    t1 = mk(6'b001101, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, -64'sd8, 1'b0);
    t1.branch = 1'b1; t1.f3 = 3'b110; t1.pc = 64'h1000;
    send(t1, 0, none);
    check("dir_bltu_taken",  64'(out_pc_src), 64'd1);
    check("dir_bltu_target", out_branch_target, 64'h0FF8);
    t1.f3 = 3'b100;
    send(t1, 0, none);
    check("dir_blt_taken", 64'(out_pc_src), 64'd0);
    idle(1);

    // div -7/2 with rem held during the stall, then an add held behind it.
    t1 = mk(6'b100011, -64'sd7, 64'd2, 64'd0, 1'b0);
    t2 = mk(6'b100101, -64'sd7, 64'd2, 64'd0, 1'b0);
    send(t1, 1, t2);
    check("dir_div_valid", 64'(out_valid), 64'd1);
    check("dir_div", out_alu_result, -64'sd3);
    cur = mk(6'b001100, 64'd40, 64'd2, 64'd0, 1'b0);
    send(t2, 1, cur);
    check("dir_rem", out_alu_result, -64'sd1);
    send(cur, 0, none);
    check("dir_held_add", out_alu_result, 64'd42);
    idle(1);

    // Divide corner cases.
    send(mk(6'b100100, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'd0, 1'b0), 0, none);
    check("dir_divu_zero", out_alu_result, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(1);
    send(mk(6'b100101, 64'h8000_0000_0000_0000, '1, 64'd0, 1'b0), 0, none);
    check("dir_rem_ovf", out_alu_result, 64'd0);
    idle(1);

    // Reset 30 iterations into a divide: no result may ever appear.
    apply(mk(6'b100011, 64'd1000, 64'd7, 64'd0, 1'b0), 1'b1);
    @(posedge clk); #1;
    apply(rand_txn(), 1'b0);
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle(80);
    check("post_reset_stall", 64'(ex_stall), 64'd0);
    check("post_reset_valid", 64'(out_valid), 64'd0);

    // Random traffic with held bundles and occasional gaps.
    cur = rand_txn();
    for (int i = 0; i < 250; i++) begin
      nxt = rand_txn();
      if ($urandom_range(0, 7) == 0) begin
        send(cur, 0, nxt);
        idle(1);
      end else begin
        send(cur, 1, nxt);
      end
      cur = nxt;
    end
    send(cur, 0, none);
    idle(1);

    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    #1;
    check("drain", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
